// File: rtl/display_scanner.sv
`default_nettype none
// ============================================================================
// Module      : display_scanner
// Description : Time-multiplexed 7-segment driver with a blank/show slot FSM,
//               per-frame input snapshot and built-in hex decode.
//               Optional leading-zero blanking: DISPLAY_SCANNER_LZ_BLANK_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module display_scanner #(
    parameter int DIGITS       = 4,
    parameter int REFRESH_DIV  = 50000,
    parameter int BLANK_CYCLES = 500,
    parameter bit ACTIVE_LOW   = 1'b1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  enable,
    input  logic [4*DIGITS-1:0]   digits_in,
    input  logic [DIGITS-1:0]     dp_in,
    output logic [6:0]            segments,
    output logic                  dp,
    output logic [DIGITS-1:0]     anode,
    output logic                  frame_done
);

    localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    localparam logic [PW-1:0] c_pre_last   = PW'(REFRESH_DIV - 1);
    localparam logic [PW-1:0] c_blank_last = PW'(BLANK_CYCLES - 1);
    localparam logic [IW-1:0] c_idx_last   = IW'(DIGITS - 1);

    localparam logic [1:0] c_st_idle  = 2'd0;
    localparam logic [1:0] c_st_blank = 2'd1;
    localparam logic [1:0] c_st_show  = 2'd2;

    // XOR masks: an "off" pattern doubles as the polarity inverter
    localparam logic [6:0]        c_seg_off   = ACTIVE_LOW ? 7'h7F : 7'h00;
    localparam logic [DIGITS-1:0] c_anode_off = {DIGITS{ACTIVE_LOW}};
    localparam logic              c_dp_off    = ACTIVE_LOW;

    function automatic logic [6:0] seg_decode(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'h0:    s = 7'h3F;
            4'h1:    s = 7'h06;
            4'h2:    s = 7'h5B;
            4'h3:    s = 7'h4F;
            4'h4:    s = 7'h66;
            4'h5:    s = 7'h6D;
            4'h6:    s = 7'h7D;
            4'h7:    s = 7'h07;
            4'h8:    s = 7'h7F;
            4'h9:    s = 7'h6F;
            4'hA:    s = 7'h77;
            4'hB:    s = 7'h7C;
            4'hC:    s = 7'h39;
            4'hD:    s = 7'h5E;
            4'hE:    s = 7'h79;
            default: s = 7'h71;
        endcase
        return s;
    endfunction

    logic [1:0]        state_q, state_d;
    logic [IW-1:0]     idx_q, idx_d;
    logic [PW-1:0]     pre_q, pre_d;
    logic              snap_load;
    logic              fdone_d;

    logic [3:0]        snap_q [DIGITS];
    logic [DIGITS-1:0] snap_dp_q;
    logic [DIGITS-1:0] blank_flag;

    logic [6:0]        seg_q, seg_d;
    logic              dp_q, dp_d;
    logic [DIGITS-1:0] anode_q, anode_d;
    logic              fdone_q;

    // ------------------------------------------------------------------
    // Slot sequencing
    // ------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        pre_d     = pre_q;
        snap_load = 1'b0;
        fdone_d   = 1'b0;
        if (!enable) begin
            state_d = c_st_idle;
            idx_d   = '0;
            pre_d   = '0;
        end else begin
            case (state_q)
                c_st_idle: begin
                    state_d   = c_st_blank;
                    idx_d     = '0;
                    pre_d     = '0;
                    snap_load = 1'b1;
                end
                c_st_blank: begin
                    pre_d = pre_q + 1'b1;
                    if (pre_q == c_blank_last) begin
                        state_d = c_st_show;
                    end
                end
                c_st_show: begin
                    if (pre_q == c_pre_last) begin
                        pre_d   = '0;
                        state_d = c_st_blank;
                        if (idx_q == c_idx_last) begin
                            idx_d     = '0;
                            snap_load = 1'b1;
                            fdone_d   = 1'b1;
                        end else begin
                            idx_d = idx_q + 1'b1;
                        end
                    end else begin
                        pre_d = pre_q + 1'b1;
                    end
                end
                default: begin
                    state_d = c_st_idle;
                    idx_d   = '0;
                    pre_d   = '0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Leading-zero blank flags, derived from the frame snapshot only
    // ------------------------------------------------------------------
`ifdef DISPLAY_SCANNER_LZ_BLANK_EN
    always_comb begin
        logic zero_run;
        zero_run   = 1'b1;
        blank_flag = '0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            zero_run = zero_run && (snap_q[i] == 4'h0);
            blank_flag[i] = (i != 0) && zero_run && !snap_dp_q[i];
        end
    end
`else
    assign blank_flag = '0;
`endif

    // ------------------------------------------------------------------
    // Output next-state: computed from the post-edge state so that the
    // pins change on the same edge as the FSM.
    // ------------------------------------------------------------------
    always_comb begin
        logic [DIGITS-1:0] sel;
        sel = '0;
        for (int i = 0; i < DIGITS; i++) begin
            sel[i] = (idx_d == IW'(i));
        end
        anode_d = c_anode_off;
        seg_d   = c_seg_off;
        dp_d    = c_dp_off;
        if (state_d == c_st_show) begin
            anode_d = sel ^ c_anode_off;
            dp_d    = snap_dp_q[idx_d] ^ c_dp_off;
            if (!blank_flag[idx_d]) begin
                seg_d = seg_decode(snap_q[idx_d]) ^ c_seg_off;
            end
        end
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= c_st_idle;
            idx_q     <= '0;
            pre_q     <= '0;
            snap_dp_q <= '0;
            anode_q   <= c_anode_off;
            seg_q     <= c_seg_off;
            dp_q      <= c_dp_off;
            fdone_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            pre_q   <= pre_d;
            anode_q <= anode_d;
            seg_q   <= seg_d;
            dp_q    <= dp_d;
            fdone_q <= fdone_d;
            if (snap_load) begin
                snap_dp_q <= dp_in;
            end
        end
    end

    generate
        for (genvar g = 0; g < DIGITS; g++) begin : g_snap
            always_ff @(posedge clock) begin
                if (reset) begin
                    snap_q[g] <= 4'h0;
                end else if (snap_load) begin
                    snap_q[g] <= digits_in[4*g +: 4];
                end
            end
        end
    endgenerate

    assign segments   = seg_q;
    assign dp         = dp_q;
    assign anode      = anode_q;
    assign frame_done = fdone_q;

endmodule
`default_nettype wire

// File: tb/tb_display_scanner.sv
`default_nettype none
// ============================================================================
// Module      : tb_display_scanner
// Description : Randomized bench for display_scanner against a frame-timing
//               reference model (honours DISPLAY_SCANNER_LZ_BLANK_EN).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_display_scanner;

    localparam int DIGITS       = 4;
    localparam int REFRESH_DIV  = 8;
    localparam int BLANK_CYCLES = 2;
    localparam int FRAME        = DIGITS * REFRESH_DIV;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic [15:0] din;
    logic [3:0]  dpi;
    logic [6:0]  segments;
    logic        dp;
    logic [3:0]  anode;
    logic        frame_done;

    int n_tests = 0;
    int n_fail  = 0;

    // reference model state
    bit          m_run = 1'b0;
    int          m_k   = 0;
    logic [15:0] m_snap_d = '0;
    logic [3:0]  m_snap_p = '0;

    logic [6:0] seg_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                 7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    display_scanner #(
        .DIGITS      (DIGITS),
        .REFRESH_DIV (REFRESH_DIV),
        .BLANK_CYCLES(BLANK_CYCLES),
        .ACTIVE_LOW  (1'b1)
    ) dut (
        .clock     (clk),
        .reset     (rst),
        .enable    (en),
        .digits_in (din),
        .dp_in     (dpi),
        .segments  (segments),
        .dp        (dp),
        .anode     (anode),
        .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h expected %h", tag, $time, got, exp);
        end
    endtask

    // One clock: apply inputs, advance the model, compare just after the edge
    task automatic step(input logic r, input logic e, input logic [15:0] d, input logic [3:0] p);
        logic [3:0] an_e;
        logic [6:0] seg_e;
        logic       dp_e;
        logic       fd_e;
        int         slot;
        int         phase;
        bit         lz;
        rst = r; en = e; din = d; dpi = p;
        @(posedge clk);
        fd_e = 1'b0;
        if (r || !e) begin
            m_run = 1'b0;
        end else if (!m_run) begin
            m_run = 1'b1; m_k = 0; m_snap_d = d; m_snap_p = p;
        end else begin
            m_k++;
            if (m_k % FRAME == 0) begin
                m_snap_d = d; m_snap_p = p; fd_e = 1'b1;
            end
        end
        an_e = 4'hF; seg_e = 7'h7F; dp_e = 1'b1;
        phase = m_k % REFRESH_DIV;
        slot  = (m_k / REFRESH_DIV) % DIGITS;
        if (m_run && phase >= BLANK_CYCLES) begin
            an_e = 4'hF & ~(4'b0001 << slot);
            dp_e = ~m_snap_p[slot];
            lz = 1'b0;
`ifdef DISPLAY_SCANNER_LZ_BLANK_EN
            lz = (slot > 0) && !m_snap_p[slot];
            for (int j = slot; j < DIGITS; j++) begin
                if (m_snap_d[4*j +: 4] != 4'h0) lz = 1'b0;
            end
`endif
            seg_e = lz ? 7'h7F : ~seg_tab[m_snap_d[4*slot +: 4]];
        end
        #1;
        chk("anode", 32'(anode), 32'(an_e));
        chk("segments", 32'(segments), 32'(seg_e));
        chk("dp", 32'(dp), 32'(dp_e));
        chk("frame_done", 32'(frame_done), 32'(fd_e));
    endtask

    initial begin
        logic [15:0] d;
        int          fd_seen;
        rst = 1'b1; en = 1'b1; din = 16'h4321; dpi = 4'h0;

        // reset asserted with enable high, then a long run of 4321
        repeat (3) step(1'b1, 1'b1, 16'h4321, 4'h0);
        fd_seen = 0;
        for (int c = 0; c < 3 * FRAME; c++) begin
            step(1'b0, 1'b1, 16'h4321, 4'h0);
            if (frame_done) fd_seen++;
        end
        chk("fd_count_3frames", 32'(fd_seen), 32'd2);

        // inputs change while digit 2 is on screen: hidden until next frame
        for (int c = 0; c < 20; c++) step(1'b0, 1'b1, 16'h4321, 4'h0);
        for (int c = 0; c < 2 * FRAME; c++) step(1'b0, 1'b1, 16'hABCD, 4'h0);

        // reset in the middle of a scan
        step(1'b1, 1'b1, 16'hABCD, 4'h0);
        // enable dropped during digit 1 SHOW, then re-enabled
        for (int c = 0; c < 12; c++) step(1'b0, 1'b1, 16'h4321, 4'h0);
        step(1'b0, 1'b0, 16'h4321, 4'h0);
        for (int c = 0; c < FRAME + 4; c++) step(1'b0, 1'b1, 16'h4321, 4'h0);

        // every hex code across four frames, dp on digit 2
        step(1'b1, 1'b1, 16'h0, 4'h0);
        for (int f = 0; f < 4; f++) begin
            d = {4'(4*f+3), 4'(4*f+2), 4'(4*f+1), 4'(4*f)};
            for (int c = 0; c < FRAME; c++) step(1'b0, 1'b1, d, 4'b0100);
        end

        // leading-zero patterns
        for (int c = 0; c < FRAME + 2; c++) step(1'b0, 1'b1, 16'h0050, 4'h0);
        for (int c = 0; c < 2 * FRAME; c++) step(1'b0, 1'b1, 16'h0000, 4'h0);
        for (int c = 0; c < 2 * FRAME; c++) step(1'b0, 1'b1, 16'h0300, 4'b0100);

        // randomized traffic with occasional enable drops and resets
        d = 16'($urandom);
        for (int c = 0; c < 1500; c++) begin
            if ($urandom_range(0, 15) == 0) d = 16'($urandom) & (($urandom_range(0, 1) != 0) ? 16'h00FF : 16'hFFFF);
            step(($urandom_range(0, 199) == 0), ($urandom_range(0, 63) != 0), d, 4'($urandom));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
